// File: rtl/mem_bus_bridge.sv
// Core load/store to valid/ready bus bridge; 4 cycles capture-to-done minimum, one access outstanding.
// Backpressure: core stalled while busy; bus_valid held until bus_ready, withdrawn only on timeout abort.
module mem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic [31:0] core_rdata,
  output logic        core_done,
  output logic        core_err,
  output logic        core_stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          timeout;

  logic          bus_valid_nx, bus_we_nx, core_done_nx, core_err_nx;
  logic [31:0]   bus_addr_nx, bus_wdata_nx, core_rdata_nx;
  logic [3:0]    bus_wstrb_nx;

  assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt == TLAST);
  assign core_stall = ((state != IDLE) || core_req) && !core_done;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    bus_valid_nx  = bus_valid;
    bus_addr_nx   = bus_addr;
    bus_we_nx     = bus_we;
    bus_wdata_nx  = bus_wdata;
    bus_wstrb_nx  = bus_wstrb;
    core_rdata_nx = core_rdata;
    core_done_nx  = 1'b0;
    core_err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          state_nx     = REQ;
          cnt_nx       = '0;
          bus_valid_nx = 1'b1;
          bus_addr_nx  = {core_addr[31:2], 2'b00};
          bus_we_nx    = core_we;
          bus_wdata_nx = core_wdata;
          bus_wstrb_nx = core_we ? core_wmask : 4'b0000;
        end
      end
      REQ: begin
        cnt_nx = cnt + CW'(1);
        // A handshake in the timeout cycle still counts as progress.
        if (bus_ready) begin
          state_nx     = WAIT;
          bus_valid_nx = 1'b0;
        end else if (timeout) begin
          state_nx      = DONE;
          bus_valid_nx  = 1'b0;
          core_done_nx  = 1'b1;
          core_err_nx   = 1'b1;
          core_rdata_nx = '0;
        end
      end
      WAIT: begin
        cnt_nx = cnt + CW'(1);
        if (bus_rvalid) begin
          state_nx      = DONE;
          core_done_nx  = 1'b1;
          core_err_nx   = bus_rerr;
          core_rdata_nx = bus_rdata;
        end else if (timeout) begin
          state_nx      = DONE;
          core_done_nx  = 1'b1;
          core_err_nx   = 1'b1;
          core_rdata_nx = '0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        bus_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      core_rdata <= '0;
      core_done  <= 1'b0;
      core_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bus_valid  <= bus_valid_nx;
      bus_addr   <= bus_addr_nx;
      bus_we     <= bus_we_nx;
      bus_wdata  <= bus_wdata_nx;
      bus_wstrb  <= bus_wstrb_nx;
      core_rdata <= core_rdata_nx;
      core_done  <= core_done_nx;
      core_err   <= core_err_nx;
    end
  end

endmodule
